// File: rtl/bus_memory_if.sv
// Address/command half of the single-master CPU bus.
// The tristate data line stays a plain inout port so it resolves in the enclosing net.
interface bus_memory_if;
    logic [31:0] address;
    logic        rw;

    modport master (
        output address,
        output rw
    );

    modport slave (
        input address,
        input rw
    );
endinterface

// File: rtl/bus_memory.sv
// Memory-side bus responder: one word access per clock into RAM or a small MMIO page
// (cycle counter, output port, sticky bus-error flag), owning the data-line output enable.
module bus_memory #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  logic               clock,
    input  logic               reset,
    bus_memory_if.slave        bus,
    inout  wire  [31:0]        data,
    output logic [31:0]        io_out,
    output logic               bus_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] rdata_reg, rdata_next;
    logic [31:0] cycle_cnt_reg, cycle_cnt_next;
    logic [31:0] io_out_reg, io_out_next;
    logic        bus_err_reg, bus_err_next;
    logic        ram_rd, ram_we;
    logic        oe;

    logic [31:0] mem [DEPTH];

    // Address decode on the sampled address.
    logic             is_write;
    logic             hit_ram, hit_cnt, hit_out, hit_stat, hit_none;
    logic [IDX_W-1:0] idx;

    // Anything but a clean 1 on rw (including X/Z in simulation) falls to the read path.
    assign is_write = (bus.rw == 1'b1);
    assign idx      = bus.address[IDX_W-1:0];
    assign hit_ram  = (bus.address < 32'(DEPTH));
    assign hit_cnt  = (bus.address == MMIO_BASE);
    assign hit_out  = (bus.address == MMIO_BASE + 32'd1);
    assign hit_stat = (bus.address == MMIO_BASE + 32'd2);
    assign hit_none = !(hit_ram || hit_cnt || hit_out || hit_stat);

    always_comb begin
        state_next     = state_reg;
        rdata_next     = rdata_reg;
        cycle_cnt_next = cycle_cnt_reg + 32'd1;
        io_out_next    = io_out_reg;
        bus_err_next   = bus_err_reg;
        ram_rd         = 1'b0;
        ram_we         = 1'b0;

        if (is_write) begin
            state_next = IDLE;
            ram_we     = hit_ram;
            // A CNT write overrides this edge's increment.
            if (hit_cnt)  cycle_cnt_next = data;
            if (hit_out)  io_out_next    = data;
            if (hit_stat) bus_err_next   = 1'b0;
            if (hit_none) bus_err_next   = 1'b1;
        end else begin
            state_next = DRIVE;
            ram_rd     = hit_ram;
            if (hit_cnt)       rdata_next = cycle_cnt_reg;
            else if (hit_out)  rdata_next = io_out_reg;
            else if (hit_stat) rdata_next = {31'b0, bus_err_reg};
            else if (hit_none) begin
                rdata_next   = 32'd0;
                bus_err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            rdata_reg     <= 32'd0;
            cycle_cnt_reg <= 32'd0;
            io_out_reg    <= 32'd0;
            bus_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rdata_reg     <= ram_rd ? mem[idx] : rdata_next;
            cycle_cnt_reg <= cycle_cnt_next;
            io_out_reg    <= io_out_next;
            bus_err_reg   <= bus_err_next;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clock) begin
        if (ram_we) mem[idx] <= data;
    end

    assign oe      = (state_reg == DRIVE);
    assign data    = oe ? rdata_reg : 32'bz;
    assign io_out  = io_out_reg;
    assign bus_err = bus_err_reg;

endmodule

// File: tb/tb_bus_memory.sv
// Directed bench for bus_memory: the bench plays the CPU, hand-computed expectations.
module tb_bus_memory;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] MB    = 32'hFFFF_FF00;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tb_oe = 1'b0;
    logic [31:0] tb_wdata = 32'd0;
    logic [31:0] io_out;
    logic        bus_err;
    wire  [31:0] data;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clock = ~clock;

    bus_memory_if bus ();

    assign data = tb_oe ? tb_wdata : 32'bz;

    bus_memory #(
        .DEPTH    (DEPTH),
        .MMIO_BASE(MB)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .data   (data),
        .io_out (io_out),
        .bus_err(bus_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
    task automatic bus_read(input logic [31:0] addr);
        bus.address = addr;
        bus.rw      = 1'b0;
        tb_oe       = 1'b0;
        @(posedge clock);
        #1;
        $display("rd  addr=%h data=%h oe=%0d bus_err=%0d", addr, data, dut.oe, bus_err);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] val);
        bus.address = addr;
        bus.rw      = 1'b1;
        tb_wdata    = val;
        tb_oe       = 1'b1;
        check("own", {31'b0, dut.oe}, 32'd0);
        @(posedge clock);
        #1;
        tb_oe = 1'b0;
        $display("wr  addr=%h data=%h io_out=%h bus_err=%0d", addr, val, io_out, bus_err);
    endtask

    // Turnaround: write cycle with the CPU not driving; hits a scratch RAM word.
    task automatic bus_idle();
        bus.address = 32'(DEPTH - 1);
        bus.rw      = 1'b1;
        tb_oe       = 1'b0;
        @(posedge clock);
        #1;
        $display("idl oe=%0d", dut.oe);
    endtask

    initial begin
        bus.address = 32'd0;
        bus.rw      = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_oe",      {31'b0, dut.oe}, 32'd0);
        check("rst_io_out",  io_out, 32'd0);
        check("rst_bus_err", {31'b0, bus_err}, 32'd0);
        reset = 1'b0;

        bus_read(MB);
        check("cnt_first", data, 32'd0);
        check("cnt_oe", {31'b0, dut.oe}, 32'd1);

        // RAM write/read and out-of-range alias
        bus_idle();
        bus_write(32'd5, 32'hDEAD_BEEF);
        bus_read(32'd5);
        check("ram5", data, 32'hDEAD_BEEF);
        check("ram5_oe", {31'b0, dut.oe}, 32'd1);
        bus_read(32'd5 + 32'(DEPTH));
        check("ram_oob", data, 32'd0);
        check("ram_oob_err", {31'b0, bus_err}, 32'd1);
        bus_read(MB + 32'd2);
        check("stat_set", data, 32'd1);
        bus_idle();
        bus_write(MB + 32'd2, 32'h0000_1234);
        check("stat_clr", {31'b0, bus_err}, 32'd0);
        bus_read(MB + 32'd2);
        check("stat_rd0", data, 32'd0);

        // Unmapped MMIO read
        bus_read(MB + 32'd3);
        check("unmap_data", data, 32'd0);
        check("unmap_err", {31'b0, bus_err}, 32'd1);
        bus_read(MB + 32'd2);
        check("stat_rd1", data, 32'd1);
        bus_idle();
        bus_write(MB + 32'd2, 32'h0);
        check("stat_clr2", {31'b0, bus_err}, 32'd0);

        // Counter: write wins, then increments, then wraps
        bus_write(MB, 32'hFFFF_FFFE);
        bus_idle();
        bus_read(MB);
        check("cnt_ff", data, 32'hFFFF_FFFF);
        bus_read(MB);
        check("cnt_wrap", data, 32'd0);

        // Output port
        bus_idle();
        bus_write(MB + 32'd1, 32'h0000_00A5);
        check("io_out", io_out, 32'h0000_00A5);
        bus_read(MB + 32'd1);
        check("out_rd", data, 32'h0000_00A5);

        // Write-then-read hazard and back-to-back reads
        bus_idle();
        bus_write(32'd7, 32'h0BAD_F00D);
        bus_read(32'd7);
        check("ram7", data, 32'h0BAD_F00D);
        bus_read(32'd5);
        check("ram5_again", data, 32'hDEAD_BEEF);

        // Unmapped write sets the flag and touches nothing else
        bus_idle();
        bus_write(MB + 32'd2, 32'h0);
        bus_write(MB + 32'h20, 32'h1111_1111);
        check("unmap_wr_err", {31'b0, bus_err}, 32'd1);
        check("unmap_wr_io", io_out, 32'h0000_00A5);

        // Reset in the middle of a driven read
        bus_read(32'd5);
        check("pre_rst", data, 32'hDEAD_BEEF);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_oe",   {31'b0, dut.oe}, 32'd0);
        check("mid_rst_io",   io_out, 32'd0);
        check("mid_rst_err",  {31'b0, bus_err}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus_read(MB);
        check("cnt_after_rst", data, 32'd0);
        bus_read(32'd5);
        check("ram_kept", data, 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
